// File: rtl/pattern_scan_ctrl.sv
// Scan sequencer for the serial "1101" Mealy detector: flushes the detector with two
// zeros, shifts a latched word through it one bit per clock, then reports match statistics.
module pattern_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    input  logic              msb_first,
    output logic              det_i,
    input  logic              det_o,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              match_any,
    output logic [IDX_W-1:0]  first_idx,
    output logic [2:0]        state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLUSH1 = 3'd1;
    localparam logic [2:0] S_FLUSH2 = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q,  state_d;
    logic [WORD_W-1:0] shreg_q,  shreg_d;
    logic              msb_q,    msb_d;
    logic [IDX_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              any_q,    any_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        msb_d    = msb_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        any_d    = any_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = data_in;
                    msb_d   = msb_first;
                    cnt_d   = '0;
                    any_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_FLUSH1;
                end
            end
            S_FLUSH1: state_d = S_FLUSH2;
            S_FLUSH2: begin
                bitcnt_d = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d  = msb_q ? {shreg_q[WORD_W-2:0], 1'b0} : {1'b0, shreg_q[WORD_W-1:1]};
                bitcnt_d = bitcnt_q + 1'b1;
                // det_o belongs to the bit driven this cycle, so bitcnt_q is its scan index
                if (det_o) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (!any_q) begin
                        any_d = 1'b1;
                        idx_d = bitcnt_q;
                    end
                end
                if (bitcnt_q == IDX_W'(WORD_W - 1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d == S_FLUSH1) || (state_d == S_FLUSH2) || (state_d == S_SHIFT);
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            msb_q    <= 1'b0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            any_q    <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            msb_q    <= msb_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            any_q    <= any_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Driven only from registered state, never from det_o, so no combinational loop.
    assign det_i     = (state_q == S_SHIFT) ? (msb_q ? shreg_q[WORD_W-1] : shreg_q[0]) : 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;
    assign match_any = any_q;
    assign first_idx = idx_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: behavioural "1101" detectors, directed scans, and a
// scoreboard that pops expected results on every done pulse.
module tb_pattern_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic              msb_first = 1'b0;
    logic [WORD_W-1:0] data_in = '0;

    logic              det_i, det_o, busy, done, match_any;
    logic [CNT_W-1:0]  match_cnt;
    logic [IDX_W-1:0]  first_idx;
    logic [2:0]        state;

    logic              det_i_s, det_o_s, busy_s, done_s, match_any_s;
    logic [0:0]        match_cnt_s;
    logic [IDX_W-1:0]  first_idx_s;
    logic [2:0]        state_s;

    logic [1:0] ds   = 2'd0;
    logic [1:0] ds_s = 2'd0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [4:0] exp_s_q[$];

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in), .msb_first(msb_first),
        .det_i(det_i), .det_o(det_o), .busy(busy), .done(done), .match_cnt(match_cnt),
        .match_any(match_any), .first_idx(first_idx), .state_o(state)
    );

    pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(1), .IDX_W(IDX_W)) u_dut_sat (
        .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in), .msb_first(msb_first),
        .det_i(det_i_s), .det_o(det_o_s), .busy(busy_s), .done(done_s), .match_cnt(match_cnt_s),
        .match_any(match_any_s), .first_idx(first_idx_s), .state_o(state_s)
    );

    // Overlapping "1101" Mealy detector; free-running, not tied to n_rst
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd2 : 2'd0;
            2'd2:    return b ? 2'd2 : 2'd3;
            default: return b ? 2'd1 : 2'd0;
        endcase
    endfunction

    always @(posedge clk) ds   <= det_next(ds, det_i);
    always @(posedge clk) ds_s <= det_next(ds_s, det_i_s);
    assign det_o   = (ds == 2'd3) && det_i;
    assign det_o_s = (ds_s == 2'd3) && det_i_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("result", {match_cnt, match_any, first_idx}, exp_q.pop_front());
        end
        if (done_s) begin
            if (exp_s_q.size() == 0) check("unexpected_done_sat", 32'd1, 32'd0);
            else check("result_sat", {match_cnt_s, match_any_s, first_idx_s}, exp_s_q.pop_front());
        end
    end

    task automatic run_scan(input logic [7:0] d, input logic m, input logic [3:0] cnt,
                            input logic [2:0] idx, input bit noise);
        bit seen;
        logic any;
        any = (cnt != 4'd0);
        @(negedge clk);
        start = 1'b1; data_in = d; msb_first = m;
        exp_q.push_back({cnt, any, idx});
        exp_s_q.push_back({any, any, idx});
        @(posedge clk);
        #1 start = 1'b0;
        if (noise) begin
            data_in = ~d; msb_first = ~m;
        end
        seen = 1'b0;
        for (int k = 1; k <= WORD_W + 6 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) check("cleared_at_accept", {match_cnt, match_any, first_idx}, 32'd0);
            if (k <= 2) check("flush_det_i", det_i, 1'b0);
            if (k <= WORD_W + 2) check("busy_high", busy, 1'b1);
            if (done) begin
                seen = 1'b1;
                check("done_latency", k, WORD_W + 3);
                check("busy_low_in_done", busy, 1'b0);
            end
            if (noise) start = (k == 1 || k == 5 || k == WORD_W + 3);
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("results_stable", {match_cnt, match_any, first_idx}, {cnt, any, idx});
    endtask

    task automatic reset_mid_scan();
        @(negedge clk);
        start = 1'b1; data_in = 8'b1101_1011; msb_first = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_state_shift", state, 3'd3);
        check("mid_cnt_before_rst", match_cnt, 4'd1);
        n_rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_det_i", det_i, 1'b0);
        check("rst_results", {match_cnt, match_any, first_idx}, 32'd0);
        check("rst_state", state, 3'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check("no_done_after_rst", done, 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_det_i", det_i, 1'b0);
        check("reset_results", {match_cnt, match_any, first_idx}, 32'd0);
        check("reset_state", state, 3'd0);
        n_rst = 1'b1;
        @(negedge clk);

        run_scan(8'b1101_0000, 1'b1, 4'd1, 3'd3, 1'b0);
        run_scan(8'b1101_1011, 1'b1, 4'd2, 3'd3, 1'b0);
        run_scan(8'b0000_1011, 1'b0, 4'd1, 3'd3, 1'b0);
        run_scan(8'b0000_1011, 1'b1, 4'd0, 3'd0, 1'b0);
        run_scan(8'b0000_0110, 1'b1, 4'd0, 3'd0, 1'b0);
        run_scan(8'b1000_0000, 1'b1, 4'd0, 3'd0, 1'b0);
        run_scan(8'b1101_1011, 1'b1, 4'd2, 3'd3, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("no_extra_done", done, 1'b0);
        end
        reset_mid_scan();
        run_scan(8'b1101_1011, 1'b1, 4'd2, 3'd3, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("queue_drained_sat", exp_s_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
